// File: rtl/fpu_misc_pkg.sv
// Shared FPU helper definitions: radix-4 Booth digit codes, multiplier FSM states,
// and the triple-to-digit recoder.
package fpu_misc_pkg;

    // Signed 3-bit digit codes: value = code interpreted as two's complement
    localparam logic [2:0] BOOTH_0  = 3'b000;
    localparam logic [2:0] BOOTH_P1 = 3'b001;
    localparam logic [2:0] BOOTH_P2 = 3'b010;
    localparam logic [2:0] BOOTH_N1 = 3'b111;
    localparam logic [2:0] BOOTH_N2 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [2:0] booth_encode(input logic [2:0] triple);
        logic [2:0] code;
        case (triple)
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_N2;
            3'b101, 3'b110: code = BOOTH_N1;
            default:        code = BOOTH_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_digit_r4.sv
// Radix-4 Booth partial-product generator, combinational (0 cycles), no handshake.
// Negative digits yield the one's complement with neg_cin=1; the caller adds the carry.
module booth_digit_r4
    import fpu_misc_pkg::*;
#(
    parameter int EW = 10
) (
    input  logic [2:0]  triple,
    input  logic [EW-1:0] mcand,
    output logic [EW:0] pp,
    output logic        neg_cin
);

    logic [2:0]  code;
    logic [EW:0] mul1;
    logic [EW:0] mul2;

    assign code = booth_encode(triple);
    assign mul1 = {mcand[EW-1], mcand};
    assign mul2 = {mcand, 1'b0};

    always_comb begin
        pp      = '0;
        neg_cin = 1'b0;
        case (code)
            BOOTH_P1: pp = mul1;
            BOOTH_P2: pp = mul2;
            BOOTH_N1: begin
                pp      = ~mul1;
                neg_cin = 1'b1;
            end
            BOOTH_N2: begin
                pp      = ~mul2;
                neg_cin = 1'b1;
            end
            default:  pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle; out_valid seen N+1 edges after accept.
// Result holds in DONE until out_ready; no new accept until the result is consumed.
module booth_mul_r4_seq
    import fpu_misc_pkg::*;
#(
    parameter int DWIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     a,
    input  logic [DWIDTH-1:0]     b,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   p,
    output logic                  busy
);

    localparam int EW   = DWIDTH + 2;
    localparam int N    = EW / 2;
    localparam int ACCW = 2 * DWIDTH;
    localparam int CW   = $clog2(N + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_sum;
    logic [ACCW-1:0] pp_ext;
    logic [ACCW-1:0] cin_ext;
    logic [EW-1:0]   a_reg;
    logic [EW:0]     b_sh;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [EW:0]     pp;
    logic            neg_cin;
    logic [CW:0]     shamt;
    logic            accept;
    logic            last_digit;

    assign in_ready   = (state == ST_IDLE) && !rst;
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign p          = acc;
    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CW'(N - 1));

    // Two extra bits keep unsigned operands positive under signed Booth recoding
    assign a_ext = {{2{signed_mode & a[DWIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[DWIDTH-1]}}, b};

    booth_digit_r4 #(
        .EW (EW)
    ) u_digit (
        .triple  (b_sh[2:0]),
        .mcand   (a_reg),
        .pp      (pp),
        .neg_cin (neg_cin)
    );

    // Only the low ACCW bits of the product are kept, so wrap-around is harmless
    assign shamt   = {cnt, 1'b0};
    assign pp_ext  = {{(ACCW-EW-1){pp[EW]}}, pp} << shamt;
    assign cin_ext = {{(ACCW-1){1'b0}}, neg_cin} << shamt;
    assign acc_sum = acc + pp_ext + cin_ext;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)     state_next = ST_CALC;
            ST_CALC: if (last_digit) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_sh  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= '0;
                acc   <= '0;
                a_reg <= a_ext;
                b_sh  <= {b_ext, 1'b0};
            end else if (state == ST_CALC) begin
                acc  <= acc_sum;
                cnt  <= cnt + 1'b1;
                b_sh <= {2'b00, b_sh[EW:2]};
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_r4_seq.sv
// Self-checking bench for booth_mul_r4_seq at DWIDTH=8: directed cases plus randomized
// back-to-back traffic scored against a plain a*b reference.
module tb_booth_mul_r4_seq;

    localparam int DW  = 8;
    localparam int N   = (DW + 2) / 2;
    localparam int LAT = N + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic            signed_mode;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] p;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    booth_mul_r4_seq #(.DWIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                                input logic sm);
        logic signed [2*DW-1:0] sx, sy;
        logic [2*DW-1:0] ux, uy;
        if (sm) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        ux = {{DW{1'b0}}, x};
        uy = {{DW{1'b0}}, y};
        return ux * uy;
    endfunction

    // Issue one operation with out_ready held high and check result, timing and handshake
    task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic tsm,
                          input logic [2*DW-1:0] exp, input string tag);
        int  g;
        int  lat;
        bit  rdy_low;
        out_ready   = 1'b1;
        a           = ta;
        b           = tb_;
        signed_mode = tsm;
        in_valid    = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        check({tag, "_rdy"}, in_ready, 1'b1);
        tick();
        in_valid    = 1'b0;
        a           = DW'($urandom);
        b           = DW'($urandom);
        signed_mode = ~tsm;
        lat     = 1;
        rdy_low = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_p"}, p, exp);
        check({tag, "_rdylow"}, {rdy_low, in_ready, busy}, 3'b101);
        tick();
        check({tag, "_pulse"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        int g;
        bit stable;
        bit never;
        logic [2*DW-1:0] held;
        logic [2*DW-1:0] q[$];
        int acc_cnt;
        int res_cnt;
        int cyc;
        bit took;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (3) tick();
        check("rst_state", {in_ready, out_valid, busy}, 3'b000);
        check("rst_p", p, 16'h0000);
        rst = 1'b0;
        #1;
        check("rst_release_rdy", in_ready, 1'b1);
        tick();

        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
        run_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f");
        run_op(8'h80, 8'h02, 1'b0, 16'h0100, "u_80_02");
        run_op(8'h80, 8'h02, 1'b1, 16'hFF00, "s_80_02");
        run_op(8'h00, 8'hA7, 1'b0, 16'h0000, "u_00_a7");
        run_op(8'h00, 8'hA7, 1'b1, 16'h0000, "s_00_a7");

        // Backpressure: hold the result for 10 cycles
        out_ready   = 1'b0;
        a           = 8'h12;
        b           = 8'h34;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        tick();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin
            tick();
            g++;
        end
        check("bp_valid", out_valid, 1'b1);
        held   = p;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!out_valid || in_ready || p !== held) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_p", held, 16'h03A8);
        out_ready = 1'b1;
        tick();
        check("bp_release", {out_valid, in_ready, busy}, 3'b010);

        // Reset in the third CALC cycle discards the operation
        a           = 8'hC3;
        b           = 8'h5A;
        signed_mode = 1'b1;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_state", {in_ready, busy, out_valid}, 3'b000);
        rst = 1'b0;
        #1;
        check("mid_rdy_after", in_ready, 1'b1);
        never = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid) never = 1'b0;
        end
        check("mid_no_valid", never, 1'b1);
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, "post_rst");

        // Randomized back-to-back traffic with random consumer stalls
        acc_cnt     = 0;
        res_cnt     = 0;
        cyc         = 0;
        a           = DW'($urandom);
        b           = DW'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
        in_valid    = 1'b1;
        while ((acc_cnt < 2000 || res_cnt < acc_cnt) && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rnd_extra", 1'b1, 1'b0);
                else check("rnd_p", p, q.pop_front());
                res_cnt++;
            end
            took = in_valid && in_ready;
            if (took) begin
                q.push_back(ref_mul(a, b, signed_mode));
                acc_cnt++;
            end
            tick();
            cyc++;
            if (acc_cnt >= 2000) in_valid = 1'b0;
            else if (took) begin
                a           = DW'($urandom);
                b           = DW'($urandom);
                signed_mode = 1'($urandom_range(0, 1));
            end
        end
        check("rnd_accepts", acc_cnt, 2000);
        check("rnd_results", res_cnt, 2000);
        never = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid) never = 1'b0;
        end
        check("rnd_no_extra", never, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
